// File: rtl/pulse_sched_pkg.sv
// Shared definitions for the pulse-train scheduler: FSM encoding and default widths.
// Option macro PULSE_SCHED_FIXED_PRIO_EN is consumed by rr_arbiter2.
package pulse_sched_pkg;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter holding the round-robin priority pointer.
// With PULSE_SCHED_FIXED_PRIO_EN defined, requester 0 always wins and the pointer is removed.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       last,
  output logic [1:0] gnt
);
`ifdef PULSE_SCHED_FIXED_PRIO_EN
  logic w_unused;
  assign w_unused = &{1'b0, clk, rst_n, update, last};

  always_comb begin
    gnt = 2'b00;
    if (req[0])      gnt = 2'b01;
    else if (req[1]) gnt = 2'b10;
  end
`else
  logic r_ptr;

  // After a burst, priority passes to the requester that was not served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_ptr <= 1'b0;
    else if (update) r_ptr <= ~last;
  end

  always_comb begin
    gnt = 2'b00;
    if (req[r_ptr])       gnt[r_ptr]  = 1'b1;
    else if (req[~r_ptr]) gnt[~r_ptr] = 1'b1;
  end
`endif
endmodule

// File: rtl/pulse_train_sched.sv
// Shares one pulse output between two requesters: arbitrates, latches the winner's
// pattern and plays cnt periods of hi/lo cycles. Option macro: PULSE_SCHED_FIXED_PRIO_EN.
module pulse_train_sched
  import pulse_sched_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] hi_len0,
  input  logic [LEN_W-1:0] lo_len0,
  input  logic [CNT_W-1:0] cnt0,
  input  logic [LEN_W-1:0] hi_len1,
  input  logic [LEN_W-1:0] lo_len1,
  input  logic [CNT_W-1:0] cnt1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             signal,
  output logic [1:0]       done,
  output state_t           dbg_state
);
  // Handshake: req[i] is sampled only in IDLE; gnt stays one-hot for the whole burst,
  // done[i] strobes for exactly one cycle at its end, and req changes mid-burst are ignored.
  state_t           r_state;
  logic [1:0]       r_gnt, r_done;
  logic             r_busy, r_signal;
  logic [LEN_W-1:0] r_hi, r_lo, r_phase;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]       w_arb_gnt;
  logic             w_win;
  logic [LEN_W-1:0] w_hi_sel, w_lo_sel, w_hi_eff, w_lo_eff;
  logic [CNT_W-1:0] w_cnt_sel;

  rr_arbiter2 u_arb (
    .clk    (clock),
    .rst_n  (reset_n),
    .req    (req),
    .update (r_state == DONE),
    .last   (r_gnt[1]),
    .gnt    (w_arb_gnt)
  );

  assign w_win     = w_arb_gnt[1];
  assign w_hi_sel  = w_win ? hi_len1 : hi_len0;
  assign w_lo_sel  = w_win ? lo_len1 : lo_len0;
  assign w_cnt_sel = w_win ? cnt1 : cnt0;
  // A zero length would stall the phase counter, so it is promoted to one cycle.
  assign w_hi_eff  = (w_hi_sel == '0) ? LEN_W'(1) : w_hi_sel;
  assign w_lo_eff  = (w_lo_sel == '0) ? LEN_W'(1) : w_lo_sel;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_done   <= '0;
      r_busy   <= 1'b0;
      r_signal <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_phase  <= '0;
      r_cnt    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (|req) begin
            r_gnt  <= w_arb_gnt;
            r_busy <= 1'b1;
            r_hi   <= w_hi_eff;
            r_lo   <= w_lo_eff;
            r_cnt  <= w_cnt_sel;
            if (w_cnt_sel == '0) begin
              r_state <= DONE;
              r_done  <= w_arb_gnt;
            end else begin
              r_state  <= HIGH;
              r_signal <= 1'b1;
              r_phase  <= w_hi_eff;
            end
          end
        end
        HIGH: begin
          if (r_phase == LEN_W'(1)) begin
            r_state  <= LOW;
            r_signal <= 1'b0;
            r_phase  <= r_lo;
          end else begin
            r_phase <= r_phase - LEN_W'(1);
          end
        end
        LOW: begin
          if (r_phase == LEN_W'(1)) begin
            if (r_cnt == CNT_W'(1)) begin
              r_state <= DONE;
              r_cnt   <= '0;
              r_done  <= r_gnt;
            end else begin
              r_state  <= HIGH;
              r_cnt    <= r_cnt - CNT_W'(1);
              r_signal <= 1'b1;
              r_phase  <= r_hi;
            end
          end else begin
            r_phase <= r_phase - LEN_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_done  <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign busy      = r_busy;
  assign signal    = r_signal;
  assign done      = r_done;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_pulse_train_sched.sv
// Randomized bench for pulse_train_sched: a burst-level reference model queues the expected
// {gnt,busy,signal,done} per cycle and a monitor compares against the DUT every cycle.
module tb_pulse_train_sched;
  localparam int LEN_W = 4;
  localparam int CNT_W = 4;

  // ---------------- clock / reset ----------------
  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       req = 2'b00;
  logic [LEN_W-1:0] hi_len0 = '0, lo_len0 = '0, hi_len1 = '0, lo_len1 = '0;
  logic [CNT_W-1:0] cnt0 = '0, cnt1 = '0;
  logic [1:0]       gnt, done;
  logic             busy, signal;
  logic [1:0]       dbg_state;

  always #5 clock = ~clock;

  pulse_train_sched #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .hi_len0   (hi_len0),
    .lo_len0   (lo_len0),
    .cnt0      (cnt0),
    .hi_len1   (hi_len1),
    .lo_len1   (lo_len1),
    .cnt1      (cnt1),
    .gnt       (gnt),
    .busy      (busy),
    .signal    (signal),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         n_vec = 0;
  int         n_err = 0;
  logic [5:0] exp_q[$];
  logic [5:0] burst_q[$];
  bit         m_ptr = 1'b0;
  bit         m_gap = 1'b0;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t actual {gnt,busy,sig,done}=%b required=%b", name, $time, act, exp);
    end
  endtask

  // Whole burst as seen on the outputs: cnt periods of hi ones and lo zeros, then one done cycle.
  function automatic void build_burst(input logic [1:0] g, input int hi, input int lo, input int cnt);
    int h = (hi == 0) ? 1 : hi;
    int l = (lo == 0) ? 1 : lo;
    for (int p = 0; p < cnt; p++) begin
      for (int c = 0; c < h; c++) burst_q.push_back({g, 1'b1, 1'b1, 2'b00});
      for (int c = 0; c < l; c++) burst_q.push_back({g, 1'b1, 1'b0, 2'b00});
    end
    burst_q.push_back({g, 1'b1, 1'b0, g});
  endfunction

  // Reference model: one expected output vector per rising edge.
  initial forever begin
    logic [5:0] v;
    bit         win;
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      exp_q.delete();
      burst_q.delete();
      m_ptr = 1'b0;
      m_gap = 1'b0;
    end else begin
      v = 6'b0;
      if (burst_q.size() > 0) begin
        v = burst_q.pop_front();
        if (burst_q.size() == 0) m_gap = 1'b1;
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else if (req != 2'b00) begin
`ifdef PULSE_SCHED_FIXED_PRIO_EN
        win = req[0] ? 1'b0 : 1'b1;
`else
        win = req[m_ptr] ? m_ptr : ~m_ptr;
        m_ptr = ~win;
`endif
        if (win) build_burst(2'b10, int'(hi_len1), int'(lo_len1), int'(cnt1));
        else     build_burst(2'b01, int'(hi_len0), int'(lo_len0), int'(cnt0));
        v = burst_q.pop_front();
        if (burst_q.size() == 0) m_gap = 1'b1;
      end
      exp_q.push_back(v);
    end
  end

  // Monitor: compares DUT outputs mid-cycle against the model queue.
  initial forever begin
    @(negedge clock);
    if (!reset_n)              check("in_reset", {gnt, busy, signal, done}, 6'b0);
    else if (exp_q.size() > 0) check("cycle", {gnt, busy, signal, done}, exp_q.pop_front());
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_pat(input int h0, input int l0, input int c0, input int h1, input int l1, input int c1);
    hi_len0 = LEN_W'(h0); lo_len0 = LEN_W'(l0); cnt0 = CNT_W'(c0);
    hi_len1 = LEN_W'(h1); lo_len1 = LEN_W'(l1); cnt1 = CNT_W'(c1);
  endtask

  task automatic pulse_req(input logic [1:0] r, input int hold, input int after);
    req = r;
    idle(hold);
    req = 2'b00;
    idle(after);
  endtask

  task automatic async_reset(input string name);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 check(name, {gnt, busy, signal, done}, 6'b0);
    n_vec++;
    if (dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL %s_state actual=%0d required=0", name, dbg_state);
    end
    idle(2);
    #1 reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    idle(3);
    #1 reset_n = 1'b1;
    idle(1);

    set_pat(2, 3, 2, 0, 0, 0);
    pulse_req(2'b01, 1, 14);

    set_pat(1, 1, 1, 1, 1, 1);
    pulse_req(2'b11, 12, 6);

    set_pat(1, 1, 1, 1, 1, 0);
    pulse_req(2'b10, 1, 4);

    set_pat(0, 0, 1, 0, 0, 0);
    pulse_req(2'b01, 1, 5);

    // Pattern inputs change after latching; the latched pattern must be played.
    set_pat(5, 2, 2, 0, 0, 0);
    req = 2'b01;
    idle(1);
    req = 2'b00;
    idle(2);
    set_pat(1, 1, 0, 0, 0, 0);
    idle(20);

    // Reset in the middle of a long HIGH phase, then requester 0 must win a tie.
    set_pat(8, 1, 1, 1, 1, 1);
    req = 2'b01;
    idle(1);
    req = 2'b00;
    async_reset("reset_mid_high");
    idle(1);
    pulse_req(2'b11, 1, 6);

    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      req = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      set_pat($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      if (i == 200) begin
        req = 2'b11;
        async_reset("reset_random");
      end
    end

    @(negedge clock);
    req = 2'b00;
    k = 0;
    while ((burst_q.size() != 0 || m_gap) && k < 100) begin
      @(negedge clock);
      k++;
    end
    n_vec++;
    if (k >= 100) begin
      n_err++;
      $display("FAIL drain_timeout cycles=%0d required<100", k);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
